// File: rtl/sdio_data_pkg.sv
// Shared types and defaults for the SDIO data block sequencer.
package sdio_data_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_XFER,
    ST_CRC_WAIT,
    ST_CHECK,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int SIZE_W             = 10;
  localparam int COUNT_W            = 9;
  localparam int DEFAULT_BLOCK_SIZE = 512;
  localparam int DEFAULT_CRC_WAIT   = 10;
  localparam int DEFAULT_GAP_CYCLES = 2;
  localparam int DEFAULT_FIFO_DEPTH = 16;

  // A block size of zero encodes the maximum block of 512 bytes.
  function automatic logic [SIZE_W-1:0] map_block_size(input logic [SIZE_W-1:0] size);
    return (size == '0) ? SIZE_W'(DEFAULT_BLOCK_SIZE) : size;
  endfunction

endpackage

// File: rtl/sdio_data_block_ctrl_if.sv
// Command, function-stream and phy-side signals of the data block sequencer.
interface sdio_data_block_ctrl_if;
  import sdio_data_pkg::*;

  logic               i_xfer_start;
  logic               i_write_flag;
  logic [SIZE_W-1:0]  i_block_size;
  logic [COUNT_W-1:0] i_block_count;
  logic               i_abort;
  logic               o_busy;
  logic               o_done;
  logic               o_crc_err;
  logic               o_ovf_err;
  logic [COUNT_W-1:0] o_blocks_done;
  logic [7:0]         i_src_data;
  logic               i_src_valid;
  logic               o_src_ready;
  logic [7:0]         o_snk_data;
  logic               o_snk_valid;
  logic               i_snk_ready;
  logic               o_phy_activate;
  logic               o_phy_write_flag;
  logic [SIZE_W-1:0]  o_phy_data_count;
  logic               o_phy_rd_stb;
  logic [7:0]         o_phy_rd_data;
  logic               o_phy_com_rdy;
  logic               i_phy_wr_stb;
  logic [7:0]         i_phy_wr_data;
  logic               i_phy_hst_rdy;
  logic               i_phy_crc_good;

  modport master (
    output i_xfer_start, i_write_flag, i_block_size, i_block_count, i_abort,
    output i_src_data, i_src_valid, i_snk_ready,
    output i_phy_wr_stb, i_phy_wr_data, i_phy_hst_rdy, i_phy_crc_good,
    input  o_busy, o_done, o_crc_err, o_ovf_err, o_blocks_done,
    input  o_src_ready, o_snk_data, o_snk_valid,
    input  o_phy_activate, o_phy_write_flag, o_phy_data_count,
    input  o_phy_rd_stb, o_phy_rd_data, o_phy_com_rdy
  );

  modport slave (
    input  i_xfer_start, i_write_flag, i_block_size, i_block_count, i_abort,
    input  i_src_data, i_src_valid, i_snk_ready,
    input  i_phy_wr_stb, i_phy_wr_data, i_phy_hst_rdy, i_phy_crc_good,
    output o_busy, o_done, o_crc_err, o_ovf_err, o_blocks_done,
    output o_src_ready, o_snk_data, o_snk_valid,
    output o_phy_activate, o_phy_write_flag, o_phy_data_count,
    output o_phy_rd_stb, o_phy_rd_data, o_phy_com_rdy
  );

endinterface

// File: rtl/sdio_sync_fifo.sv
// Byte FIFO with first-word-fall-through head, used by whichever direction is active.
module sdio_sync_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign count   = count_reg;
  // Small enough for distributed RAM; the head is read combinationally so data
  // is available in the same cycle as the phy strobe.
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/sdio_data_block_ctrl.sv
// Splits a CMD53 data transfer into blocks and sequences the SDIO data phy per block.
module sdio_data_block_ctrl
  import sdio_data_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int CRC_WAIT   = DEFAULT_CRC_WAIT,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdio_data_block_ctrl_if.slave bus
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [9:0]  DEPTH_10  = 10'(FIFO_DEPTH);
  localparam logic [7:0]  CRC_LAST  = 8'(CRC_WAIT - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYCLES - 1);

  state_t              state_reg, state_next;
  logic                write_reg;
  logic [SIZE_W-1:0]   size_reg;
  logic [COUNT_W-1:0]  count_reg;
  logic [COUNT_W-1:0]  blocks_done_reg;
  logic                crc_err_reg;
  logic                ovf_err_reg;
  logic [SIZE_W-1:0]   xfer_cnt_reg;
  logic [SIZE_W-1:0]   fetch_cnt_reg;
  logic [7:0]          wait_cnt_reg;

  logic                start_ok, abort_now, done_exit;
  logic                src_ready, src_push, rd_stb, wr_push, snk_pop, byte_evt;
  logic                last_byte, prefetch_done, crc_fail, more_blocks, ovf_evt;
  logic [SIZE_W-1:0]   remaining, prefetch_goal;
  logic                fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [7:0]          fifo_push_data, fifo_head;
  logic [CW-1:0]       fifo_count;

  sdio_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign start_ok  = (state_reg == ST_IDLE) && bus.i_xfer_start;
  assign abort_now = (state_reg != ST_IDLE) && bus.i_abort;
  assign done_exit = (state_reg == ST_DONE) && (fifo_empty || bus.i_abort);

  // Read path: fetch is capped at the block size so the FIFO never holds bytes
  // of the following block.
  assign src_ready = !write_reg && ((state_reg == ST_ARM) || (state_reg == ST_XFER))
                     && !fifo_full && (fetch_cnt_reg < size_reg) && !bus.i_abort;
  assign src_push  = src_ready && bus.i_src_valid;
  assign rd_stb    = !write_reg && (state_reg == ST_XFER) && bus.i_phy_hst_rdy
                     && !fifo_empty && (xfer_cnt_reg < size_reg);

  assign wr_push   = write_reg && (state_reg == ST_XFER) && bus.i_phy_wr_stb;
  assign snk_pop   = write_reg && !fifo_empty && bus.i_snk_ready;
  assign ovf_evt   = wr_push && fifo_full && !snk_pop;

  assign byte_evt      = rd_stb || wr_push;
  assign last_byte     = byte_evt && (xfer_cnt_reg == size_reg - 10'd1);
  assign remaining     = size_reg - xfer_cnt_reg;
  assign prefetch_goal = (remaining < DEPTH_10) ? remaining : DEPTH_10;
  assign prefetch_done = (10'(fifo_count) >= prefetch_goal);
  assign crc_fail      = write_reg && !bus.i_phy_crc_good;
  assign more_blocks   = (count_reg == '0) || ((blocks_done_reg + 9'd1) != count_reg);

  assign fifo_push      = src_push || wr_push;
  assign fifo_push_data = write_reg ? bus.i_phy_wr_data : bus.i_src_data;
  assign fifo_pop       = rd_stb || snk_pop;
  assign fifo_flush     = start_ok || abort_now;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (bus.i_xfer_start) state_next = ST_ARM;
      ST_ARM:      if (write_reg || prefetch_done) state_next = ST_XFER;
      ST_XFER:     if (last_byte) state_next = ST_CRC_WAIT;
      ST_CRC_WAIT: if (wait_cnt_reg == CRC_LAST) state_next = ST_CHECK;
      ST_CHECK:    state_next = (!crc_fail && more_blocks) ? ST_GAP : ST_DONE;
      ST_GAP:      if (wait_cnt_reg == GAP_LAST) state_next = ST_ARM;
      ST_DONE:     if (done_exit) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
    if (abort_now && (state_reg != ST_DONE)) state_next = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      write_reg       <= 1'b0;
      size_reg        <= '0;
      count_reg       <= '0;
      blocks_done_reg <= '0;
      crc_err_reg     <= 1'b0;
      ovf_err_reg     <= 1'b0;
      xfer_cnt_reg    <= '0;
      fetch_cnt_reg   <= '0;
      wait_cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        write_reg       <= bus.i_write_flag;
        size_reg        <= map_block_size(bus.i_block_size);
        count_reg       <= bus.i_block_count;
        blocks_done_reg <= '0;
        crc_err_reg     <= 1'b0;
        ovf_err_reg     <= 1'b0;
      end
      if ((state_reg == ST_ARM) || (state_reg == ST_XFER)) begin
        if (byte_evt) xfer_cnt_reg  <= xfer_cnt_reg + 10'd1;
        if (src_push) fetch_cnt_reg <= fetch_cnt_reg + 10'd1;
      end else begin
        xfer_cnt_reg  <= '0;
        fetch_cnt_reg <= '0;
      end
      wait_cnt_reg <= ((state_next == state_reg) &&
                       ((state_reg == ST_CRC_WAIT) || (state_reg == ST_GAP)))
                      ? wait_cnt_reg + 8'd1 : 8'd0;
      if ((state_reg == ST_CHECK) && !abort_now) begin
        if (crc_fail) crc_err_reg <= 1'b1;
        else          blocks_done_reg <= blocks_done_reg + 9'd1;
      end
      if (ovf_evt) ovf_err_reg <= 1'b1;
    end
  end

  assign bus.o_busy           = (state_reg != ST_IDLE);
  assign bus.o_done           = done_exit;
  assign bus.o_crc_err        = crc_err_reg;
  assign bus.o_ovf_err        = ovf_err_reg;
  assign bus.o_blocks_done    = blocks_done_reg;
  assign bus.o_src_ready      = src_ready;
  assign bus.o_snk_valid      = write_reg && !fifo_empty;
  assign bus.o_snk_data       = (write_reg && !fifo_empty) ? fifo_head : 8'h00;
  assign bus.o_phy_activate   = (state_reg == ST_ARM) || (state_reg == ST_XFER) ||
                                (state_reg == ST_CRC_WAIT) || (state_reg == ST_CHECK);
  assign bus.o_phy_write_flag = write_reg;
  assign bus.o_phy_data_count = size_reg;
  assign bus.o_phy_rd_stb     = rd_stb;
  assign bus.o_phy_rd_data    = (!write_reg && (state_reg == ST_XFER) && !fifo_empty)
                                ? fifo_head : 8'hFF;
  assign bus.o_phy_com_rdy    = !write_reg && (state_reg == ST_XFER);

endmodule

// File: tb/tb_sdio_data_block_ctrl.sv
// Directed scoreboard bench for the SDIO data block sequencer.
module tb_sdio_data_block_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sdio_data_block_ctrl_if bus();

  sdio_data_block_ctrl #(.FIFO_DEPTH(16), .CRC_WAIT(10), .GAP_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] src_byte;
  bit         src_took;
  int         stb_cnt   = 0;
  int         snk_cnt   = 0;
  int         done_cnt  = 0;
  int         act_rises = 0;
  int         low_run   = 0;
  int         last_gap  = -1;
  logic       prev_act  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, 32'(obs), 32'(e));
    end
  endtask

  // Samples the DUT mid-cycle, after inputs have settled and before the next edge.
  task automatic observe();
    src_took = bus.i_src_valid && bus.o_src_ready;
    if (src_took) exp_q.push_back(bus.i_src_data);
    if (bus.o_phy_rd_stb) begin
      stb_cnt++;
      pop_check("rd_data", bus.o_phy_rd_data);
    end
    if (bus.o_snk_valid && bus.i_snk_ready) begin
      snk_cnt++;
      pop_check("snk_data", bus.o_snk_data);
    end
    if (bus.o_done) done_cnt++;
    if (bus.o_phy_activate && !prev_act) begin
      act_rises++;
      if (low_run > 0) last_gap = low_run;
    end
    if (!bus.o_busy || bus.o_phy_activate) low_run = 0;
    else low_run++;
    prev_act = bus.o_phy_activate;
  endtask

  task automatic cycle();
    #2;
    observe();
    @(posedge clk);
    #1;
    if (src_took) begin
      src_byte = src_byte + 8'd1;
      bus.i_src_data = src_byte;
    end
  endtask

  task automatic start_xfer(input logic w, input logic [9:0] size, input logic [8:0] count);
    bus.i_write_flag  = w;
    bus.i_block_size  = size;
    bus.i_block_count = count;
    bus.i_xfer_start  = 1'b1;
    cycle();
    bus.i_xfer_start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  task automatic wait_act(input string tag);
    int n = 0;
    while (!bus.o_phy_activate && n < 100) begin
      cycle();
      n++;
    end
    check({tag, "_activate_seen"}, 32'(bus.o_phy_activate), 1);
  endtask

  // Emulates the phy receiving a block; only the first accept_limit bytes are expected at the sink.
  task automatic write_block(input string tag, input logic [7:0] base, input int n, input int accept_limit);
    wait_act(tag);
    cycle();
    for (int i = 0; i < n; i++) begin
      bus.i_phy_wr_stb  = 1'b1;
      bus.i_phy_wr_data = base + 8'(i);
      if (i < accept_limit) exp_q.push_back(bus.i_phy_wr_data);
      cycle();
    end
    bus.i_phy_wr_stb = 1'b0;
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_activate"},   32'(bus.o_phy_activate), 0);
    check({p, "_busy"},       32'(bus.o_busy), 0);
    check({p, "_done"},       32'(bus.o_done), 0);
    check({p, "_crc_err"},    32'(bus.o_crc_err), 0);
    check({p, "_ovf_err"},    32'(bus.o_ovf_err), 0);
    check({p, "_blocks"},     32'(bus.o_blocks_done), 0);
    check({p, "_rd_data"},    32'(bus.o_phy_rd_data), 32'hFF);
    check({p, "_rd_stb"},     32'(bus.o_phy_rd_stb), 0);
    check({p, "_data_count"}, 32'(bus.o_phy_data_count), 0);
    check({p, "_write_flag"}, 32'(bus.o_phy_write_flag), 0);
    check({p, "_src_ready"},  32'(bus.o_src_ready), 0);
    check({p, "_snk_valid"},  32'(bus.o_snk_valid), 0);
    check({p, "_com_rdy"},    32'(bus.o_phy_com_rdy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, k0, d0, a0, n;
    rst_n              = 1'b0;
    bus.i_xfer_start   = 1'b0;
    bus.i_write_flag   = 1'b0;
    bus.i_block_size   = '0;
    bus.i_block_count  = '0;
    bus.i_abort        = 1'b0;
    src_byte           = 8'h01;
    bus.i_src_data     = src_byte;
    bus.i_src_valid    = 1'b0;
    bus.i_snk_ready    = 1'b0;
    bus.i_phy_wr_stb   = 1'b0;
    bus.i_phy_wr_data  = '0;
    bus.i_phy_hst_rdy  = 1'b0;
    bus.i_phy_crc_good = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    cycle();

    // Read, 2 blocks of 4 bytes, source bytes 01..08.
    bus.i_src_valid    = 1'b1;
    bus.i_phy_hst_rdy  = 1'b1;
    bus.i_snk_ready    = 1'b1;
    bus.i_phy_crc_good = 1'b1;
    s0 = stb_cnt;
    start_xfer(1'b0, 10'd4, 9'd2);
    check("t1_busy", 32'(bus.o_busy), 1);
    check("t1_data_count", 32'(bus.o_phy_data_count), 4);
    wait_done(200, "t1");
    check("t1_rd_stb_count", stb_cnt - s0, 8);
    check("t1_gap_cycles", last_gap, 2);
    check("t1_blocks_done", 32'(bus.o_blocks_done), 2);
    check("t1_src_next", 32'(src_byte), 9);
    check("t1_sb_empty", exp_q.size(), 0);
    check("t1_busy_after", 32'(bus.o_busy), 0);

    // Write, 1 block of 8 bytes A0..A7, good CRC.
    k0 = snk_cnt;
    start_xfer(1'b1, 10'd8, 9'd1);
    write_block("t2", 8'hA0, 8, 8);
    check("t2_write_flag", 32'(bus.o_phy_write_flag), 1);
    check("t2_data_count", 32'(bus.o_phy_data_count), 8);
    wait_done(100, "t2");
    check("t2_snk_count", snk_cnt - k0, 8);
    check("t2_crc_err", 32'(bus.o_crc_err), 0);
    check("t2_ovf_err", 32'(bus.o_ovf_err), 0);
    check("t2_blocks_done", 32'(bus.o_blocks_done), 1);
    check("t2_sb_empty", exp_q.size(), 0);

    // Write, 3 blocks requested, bad CRC on the first block ends the transfer.
    bus.i_phy_crc_good = 1'b0;
    k0 = snk_cnt;
    a0 = act_rises;
    start_xfer(1'b1, 10'd4, 9'd3);
    write_block("t3", 8'hC0, 4, 4);
    wait_done(100, "t3");
    check("t3_crc_err", 32'(bus.o_crc_err), 1);
    check("t3_blocks_done", 32'(bus.o_blocks_done), 0);
    check("t3_blocks_started", act_rises - a0, 1);
    check("t3_snk_count", snk_cnt - k0, 4);
    bus.i_phy_crc_good = 1'b1;

    // Write 32 bytes into a stalled sink: only the first 16 survive.
    bus.i_snk_ready = 1'b0;
    d0 = done_cnt;
    k0 = snk_cnt;
    start_xfer(1'b1, 10'd32, 9'd1);
    check("t4_crc_err_cleared", 32'(bus.o_crc_err), 0);
    write_block("t4", 8'h40, 32, 16);
    repeat (15) cycle();
    check("t4_ovf_err", 32'(bus.o_ovf_err), 1);
    check("t4_busy_draining", 32'(bus.o_busy), 1);
    check("t4_no_early_done", done_cnt - d0, 0);
    check("t4_snk_valid", 32'(bus.o_snk_valid), 1);
    bus.i_snk_ready = 1'b1;
    wait_done(60, "t4");
    check("t4_snk_count", snk_cnt - k0, 16);
    check("t4_sb_empty", exp_q.size(), 0);
    check("t4_blocks_done", 32'(bus.o_blocks_done), 1);

    // Unbounded read of 512-byte blocks, aborted inside block 4.
    start_xfer(1'b0, 10'd0, 9'd0);
    check("t5_data_count_512", 32'(bus.o_phy_data_count), 512);
    n = 0;
    while (bus.o_blocks_done != 9'd3 && n < 3000) begin
      cycle();
      n++;
    end
    check("t5_three_blocks", 32'(bus.o_blocks_done), 3);
    check("t5_gap_cycles", last_gap, 2);
    wait_act("t5");
    repeat (20) cycle();
    check("t5_active_before_abort", 32'(bus.o_phy_activate), 1);
    d0 = done_cnt;
    bus.i_abort = 1'b1;
    cycle();
    bus.i_abort = 1'b0;
    check("t5_activate_dropped", 32'(bus.o_phy_activate), 0);
    check("t5_done_level", 32'(bus.o_done), 1);
    cycle();
    check("t5_done_pulses", done_cnt - d0, 1);
    check("t5_busy_after", 32'(bus.o_busy), 0);
    check("t5_blocks_done", 32'(bus.o_blocks_done), 3);
    exp_q.delete();

    // Reset mid-XFER, then a start while busy must not alter the descriptor.
    s0 = stb_cnt;
    start_xfer(1'b0, 10'd8, 9'd1);
    n = 0;
    while ((stb_cnt - s0) < 3 && n < 100) begin
      cycle();
      n++;
    end
    check("t6_mid_xfer", 32'((stb_cnt - s0) >= 3), 1);
    rst_n = 1'b0;
    cycle();
    check_reset_outputs("t6_rst");
    exp_q.delete();
    rst_n = 1'b1;
    cycle();
    s0 = stb_cnt;
    start_xfer(1'b0, 10'd4, 9'd1);
    check("t6_data_count", 32'(bus.o_phy_data_count), 4);
    bus.i_write_flag  = 1'b1;
    bus.i_block_size  = 10'd9;
    bus.i_block_count = 9'd5;
    bus.i_xfer_start  = 1'b1;
    cycle();
    bus.i_xfer_start  = 1'b0;
    check("t6_count_kept", 32'(bus.o_phy_data_count), 4);
    check("t6_dir_kept", 32'(bus.o_phy_write_flag), 0);
    wait_done(200, "t6");
    check("t6_rd_stb_count", stb_cnt - s0, 4);
    check("t6_blocks_done", 32'(bus.o_blocks_done), 1);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdio_data_block_ctrl.md
Name: sdio_data_block_ctrl

Overview:
- Block-transfer sequencer directly upstream of sdio_data_phy.
- Splits a CMD53 data transfer into blocks and drives the phy's activate, direction and byte-count inputs per block.
- Sources read bytes from the function-side stream into the phy through a prefetch FIFO, and sinks phy write bytes to the function side.
- Counts blocks, checks write CRC status, and reports done/error to the command layer.

Parameters:
- FIFO_DEPTH, 16: prefetch/sink FIFO entries (power of two).
- CRC_WAIT, 10: clk cycles after the last data byte before CRC status is sampled or activate is dropped (8 CRC nibble-pairs + 2 margin).
- GAP_CYCLES, 2: activate-low cycles between blocks so the phy returns to IDLE.

Ports:
- clk  in  1  system clock, same clock as phy clk.
- rst_n  in  1  synchronous, active-low reset.
- i_xfer_start  in  1  one-cycle pulse; latches the transfer descriptor.
- i_write_flag  in  1  1 = host writes to card, 0 = card read.
- i_block_size  in  10  bytes per block; 0 means 512.
- i_block_count  in  9  number of blocks; 0 means unbounded until i_abort.
- i_abort  in  1  level; terminates the transfer (CMD52 abort).
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle pulse at end of transfer.
- o_crc_err  out  1  sticky until next i_xfer_start.
- o_ovf_err  out  1  sticky; write byte arrived with sink FIFO full.
- o_blocks_done  out  9  blocks completed in the current transfer.
- i_src_data  in  8  read-data stream.
- i_src_valid  in  1  read-data stream valid.
- o_src_ready  out  1  read-data stream ready.
- o_snk_data  out  8  write-data stream.
- o_snk_valid  out  1  write-data stream valid.
- i_snk_ready  in  1  write-data stream ready.
- o_phy_activate  out  1  to phy i_activate.
- o_phy_write_flag  out  1  to phy i_write_flag.
- o_phy_data_count  out  10  to phy i_data_count.
- o_phy_rd_stb  out  1  to phy i_data_rd_stb.
- o_phy_rd_data  out  8  to phy i_data_rd_data.
- o_phy_com_rdy  out  1  to phy i_data_com_rdy.
- i_phy_wr_stb  in  1  from phy o_data_wr_stb.
- i_phy_wr_data  in  8  from phy o_data_wr_data.
- i_phy_hst_rdy  in  1  from phy o_data_hst_rdy.
- i_phy_crc_good  in  1  from phy o_data_crc_good.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all outputs 0 except o_phy_rd_data = 8'hFF;
  - state IDLE; FIFO flushed; counters 0.
  - Reset mid-transfer drops activate in the same cycle.
- Descriptor: latched on i_xfer_start in IDLE only; ignored while o_busy. o_phy_data_count = latched size (0 maps to 10'd512). o_phy_write_flag holds the latched value for the whole transfer.
- IDLE -> ARM on i_xfer_start.
  - Clears o_crc_err, o_ovf_err and o_blocks_done.
  - o_busy = 1 from the next cycle.
- ARM:
  - o_phy_activate = 1.
  - Read: prefetch from source; go to XFER once FIFO occupancy >= min(FIFO_DEPTH, bytes remaining in block).
  - Write: go to XFER immediately.
- XFER, read:
  - o_phy_com_rdy = 1.
  - o_phy_rd_stb asserts for each cycle where i_phy_hst_rdy && FIFO non-empty && sent < size.
  - o_phy_rd_data = FIFO head, same cycle; pop on stb.
  - o_src_ready = FIFO not full and (bytes fetched for block) < size; never prefetch across a block boundary.
- XFER, write:
  - Each i_phy_wr_stb pushes i_phy_wr_data and increments the received count.
  - FIFO drains to sink on o_snk_valid && i_snk_ready.
  - Push while full: byte dropped, o_ovf_err = 1, transfer continues.
- XFER -> CRC_WAIT when the byte count reaches size.
- CRC_WAIT: count CRC_WAIT cycles, activate held, then go to CHECK.
- CHECK (1 cycle):
  - Write and !i_phy_crc_good: o_crc_err = 1, transfer ends after this block.
  - Otherwise o_blocks_done++.
- CHECK -> GAP when more blocks remain; otherwise -> DONE.
- GAP: activate = 0 for GAP_CYCLES, then -> ARM.
- DONE: activate = 0, o_done pulse, o_busy = 0 next cycle, -> IDLE.
- i_abort in any non-IDLE state:
  - activate = 0 in the next cycle, FIFO flushed, -> DONE;
  - o_blocks_done keeps completed blocks only.
- i_block_count = 0: loops GAP->ARM indefinitely; o_blocks_done wraps 511->0.
- Simultaneous abort and CHECK: abort wins; the current block is not counted.
- Write sink backpressure at DONE: FIFO contents still drain before FIFO reset on next start; DONE waits for FIFO empty unless aborted.

Decomposition:
- Package sdio_data_pkg: state encodings (IDLE, ARM, XFER, CRC_WAIT, CHECK, GAP, DONE), DEFAULT_BLOCK_SIZE = 512, CRC_WAIT and GAP defaults.
- One sub-module: sdio_sync_fifo (8-bit, FIFO_DEPTH, push/pop/flush, full/empty/count), shared by both directions since only one is active at a time.

Test Plan:
- Read, size 4, count 2, source bytes 01..08, hst_rdy = 1 -> 8 rd_stb with data 01..08, activate low for exactly 2 cycles between blocks, o_blocks_done = 2, one o_done.
- Write, size 8, count 1, phy strobes A0..A7, crc_good = 1 at CHECK -> sink receives A0..A7 in order, o_crc_err = 0, o_blocks_done = 1.
- Write, count 3, crc_good = 0 on block 1 -> o_crc_err = 1, transfer ends after block 1, o_blocks_done = 0, o_done pulses.
- Write, size 32, i_snk_ready = 0 -> bytes 17..32 dropped, o_ovf_err = 1, FIFO holds first 16.
- Read, count 0 (unbounded), i_abort after 3 blocks mid-block 4 -> activate low next cycle, o_blocks_done = 3, o_done pulse, FIFO empty.
- rst_n low mid-XFER, then i_xfer_start pulse while busy -> all outputs at reset values; a start while busy leaves the descriptor unchanged.
